// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant and one idle bubble between owners.
// Optional forced release after MAX_HOLD cycles when others wait: define RR_ARB_TIMEOUT_EN.
module rr_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       v,
  output logic       to
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nxt;
  logic [2:0] ptr, ptr_nxt;
  logic [2:0] cand, sel_idx;
  logic       sel_found;
  logic [7:0] gnt_nxt;

  generate
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("rr_arbiter_8: MAX_HOLD must be within 2..255");
    end
  endgenerate

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] cnt, cnt_nxt;
  logic       to_nxt;
`endif

  // Search starts just past the last owner so it goes last on the next pass.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = ptr;
    cand      = ptr;
    for (int i = 1; i <= 8; i++) begin
      cand = ptr + 3'(i);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_nxt   = cnt;
    to_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        gnt_nxt = 8'h00;
        if (sel_found) begin
          gnt_nxt   = 8'h01 << sel_idx;
          ptr_nxt   = sel_idx;
          state_nxt = GRANT;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_nxt   = 8'h00;
`endif
        end
      end
      GRANT: begin
        // ptr always names the current owner while in GRANT.
        if (!req[ptr]) begin
          gnt_nxt   = 8'h00;
          state_nxt = IDLE;
        end
`ifdef RR_ARB_TIMEOUT_EN
        else if (cnt == HOLD_LAST) begin
          if ((req & ~gnt) != 8'h00) begin
            gnt_nxt   = 8'h00;
            state_nxt = IDLE;
            to_nxt    = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 8'h01;
        end
`endif
      end
      default: begin
        gnt_nxt   = 8'h00;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= 8'h00;
      v     <= 1'b0;
      ptr   <= 3'd7;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      v     <= |gnt_nxt;
      ptr   <= ptr_nxt;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'h00;
      to  <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      to  <= to_nxt;
    end
  end
`else
  assign to = 1'b0;
`endif

endmodule
